// File: rtl/writeback_arbiter.sv
// writeback_arbiter: selects one of the ALU, LSU or MDU results each cycle
// and drives it as a registered register-file write.
// ALU has fixed top priority. LSU and MDU share a round-robin slot behind it.
// A starvation counter raises stall_o when a secondary source waits too long.
// Optional feature macro: WB_SCOREBOARD_EN enables the busy_o pending-write
// scoreboard. When the macro is undefined, busy_o is tied to zero.
module writeback_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_ready_o,
   input  logic        mdu_valid_i,
   input  logic [4:0]  mdu_rd_i,
   input  logic [31:0] mdu_data_i,
   output logic        mdu_ready_o,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   output logic [4:0]  rd_label_o,
   output logic        reg_write_en_o,
   output logic [31:0] wr_data_o,
   output logic [31:0] busy_o,
   output logic        stall_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic        alu_gnt, lsu_gnt, mdu_gnt, any_gnt;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   // last_lsu_q high means LSU won the previous secondary slot, so MDU is next
   logic        last_lsu_q, last_lsu_d;
   logic [4:0]  rd_label_q, rd_label_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        we_q, we_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        stall_q, stall_d;

   // Grant decision: ALU first, then round-robin between LSU and MDU; nothing is granted while in reset
   always_comb begin
      alu_gnt = rst_ni & alu_valid_i;
      lsu_gnt = rst_ni & ~alu_valid_i & lsu_valid_i & (~mdu_valid_i | ~last_lsu_q);
      mdu_gnt = rst_ni & ~alu_valid_i & mdu_valid_i & (~lsu_valid_i | last_lsu_q);
      any_gnt = alu_gnt | lsu_gnt | mdu_gnt;
   end

   assign lsu_ready_o = lsu_gnt;
   assign mdu_ready_o = mdu_gnt;

   // Select the winning result and compute next write-port and round-robin state
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      if (alu_gnt) begin
         sel_rd   = alu_rd_i;
         sel_data = alu_data_i;
      end else if (lsu_gnt) begin
         sel_rd   = lsu_rd_i;
         sel_data = lsu_data_i;
      end else if (mdu_gnt) begin
         sel_rd   = mdu_rd_i;
         sel_data = mdu_data_i;
      end
      rd_label_d = any_gnt ? sel_rd : rd_label_q;
      wr_data_d  = any_gnt ? sel_data : wr_data_q;
      we_d       = any_gnt && (sel_rd != 5'd0);
      last_lsu_d = last_lsu_q;
      if (lsu_gnt) begin
         last_lsu_d = 1'b1;
      end else if (mdu_gnt) begin
         last_lsu_d = 1'b0;
      end
   end

   // Starvation counter: counts secondary cycles without service, saturating at the limit
   always_comb begin
      cnt_d = 4'd0;
      if (lsu_gnt || mdu_gnt) begin
         cnt_d = 4'd0;
      end else if (lsu_valid_i || mdu_valid_i) begin
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1;
      end
      stall_d = (cnt_q == LIMIT);
   end

   // Arbiter state and registered write-port outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_lsu_q <= 1'b0;
         rd_label_q <= '0;
         wr_data_q  <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         stall_q    <= 1'b0;
      end else begin
         last_lsu_q <= last_lsu_d;
         rd_label_q <= rd_label_d;
         wr_data_q  <= wr_data_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         stall_q    <= stall_d;
      end
   end

   assign rd_label_o     = rd_label_q;
   assign wr_data_o      = wr_data_q;
   assign reg_write_en_o = we_q;
   assign stall_o        = stall_q;

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;

   // Pending-write scoreboard: clear on grant, then set on issue so a same-cycle set wins
   always_comb begin
      busy_d = busy_q;
      if (any_gnt) begin
         busy_d[sel_rd] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != 5'd0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
   end

   // Scoreboard register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
`else
   logic unused_issue;
   assign unused_issue = ^{issue_valid_i, issue_rd_i};
   assign busy_o       = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: scenario tasks plus a write scoreboard for writeback_arbiter.
// Expected writes are queued when stimulus is driven and popped when a write appears.
module tb_writeback_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        alu_valid_i, lsu_valid_i, mdu_valid_i, issue_valid_i;
   logic [4:0]  alu_rd_i, lsu_rd_i, mdu_rd_i, issue_rd_i;
   logic [31:0] alu_data_i, lsu_data_i, mdu_data_i;
   logic        lsu_ready_o, mdu_ready_o, reg_write_en_o, stall_o;
   logic [4:0]  rd_label_o;
   logic [31:0] wr_data_o, busy_o;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   writeback_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
      .lsu_ready_o(lsu_ready_o),
      .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
      .mdu_ready_o(mdu_ready_o),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
      .rd_label_o(rd_label_o), .reg_write_en_o(reg_write_en_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .stall_o(stall_o)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: every observed write must match the oldest queued expectation
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1 && reg_write_en_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL write_scoreboard: unexpected write rd=%0d data=%h, required no write", rd_label_o, wr_data_o);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({rd_label_o, wr_data_o} !== e) begin
               errors++;
               $display("[TB] FAIL write_scoreboard: got rd=%0d data=%h, required rd=%0d data=%h",
                        rd_label_o, wr_data_o, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i = 1'b0; lsu_valid_i = 1'b0; mdu_valid_i = 1'b0; issue_valid_i = 1'b0;
      alu_rd_i = '0; lsu_rd_i = '0; mdu_rd_i = '0; issue_rd_i = '0;
      alu_data_i = '0; lsu_data_i = '0; mdu_data_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'hA0A0_0010;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd11; mdu_data_i = 32'hB0B0_0011;
      #3;
      checks++;
      if ({reg_write_en_o, rd_label_o, wr_data_o, stall_o, busy_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got we=%b rd=%0d data=%h stall=%b busy=%h, required all 0",
                  reg_write_en_o, rd_label_o, wr_data_o, stall_o, busy_o);
      end
      checks++;
      if ({lsu_ready_o, mdu_ready_o} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b, required 00", {lsu_ready_o, mdu_ready_o});
      end
      step();
      rst_ni = 1'b1;
      #1;
      checks++;
      if ({lsu_ready_o, mdu_ready_o} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_lsu_first: got %b, required 10", {lsu_ready_o, mdu_ready_o});
      end
      exp_q.push_back({5'd10, 32'hA0A0_0010});
      step();
      lsu_valid_i = 1'b0;
      exp_q.push_back({5'd11, 32'hB0B0_0011});
      step();
      mdu_valid_i = 1'b0;
      // mid-stream: ALU write, then LSU grant, then MDU favoured when reset hits
      alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h0000_0C09;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'h0000_0D10;
      exp_q.push_back({5'd9, 32'h0000_0C09});
      step();
      alu_valid_i = 1'b0;
      exp_q.push_back({5'd10, 32'h0000_0D10});
      step();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_data_i = 32'h0000_0E12;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd13; mdu_data_i = 32'h0000_0F13;
      @(negedge clk_i);
      checks++;
      if ({lsu_ready_o, mdu_ready_o} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rr_before_reset: got %b, required 01", {lsu_ready_o, mdu_ready_o});
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({reg_write_en_o, rd_label_o, wr_data_o, stall_o, lsu_ready_o, mdu_ready_o} !== '0) begin
         errors++;
         $display("[TB] FAIL midstream_reset: got we=%b rd=%0d data=%h stall=%b rdy=%b%b, required all 0",
                  reg_write_en_o, rd_label_o, wr_data_o, stall_o, lsu_ready_o, mdu_ready_o);
      end
      step();
      step();
      rst_ni = 1'b1;
      #1;
      checks++;
      if ({lsu_ready_o, mdu_ready_o} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL post_reset_lsu_first: got %b, required 10", {lsu_ready_o, mdu_ready_o});
      end
      exp_q.push_back({5'd12, 32'h0000_0E12});
      step();
      lsu_valid_i = 1'b0;
      exp_q.push_back({5'd13, 32'h0000_0F13});
      step();
      mdu_valid_i = 1'b0;
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL reset_pending: got %0d writes outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_alu_only();
      alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      step();
      alu_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({reg_write_en_o, rd_label_o, wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL alu_write: got we=%b rd=%0d data=%h, required we=1 rd=5 data=deadbeef",
                  reg_write_en_o, rd_label_o, wr_data_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (reg_write_en_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alu_single_write: got we=%b, required 0", reg_write_en_o);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_rdy [4];
      logic [4:0] exp_rd  [4];
      exp_rdy = '{2'b00, 2'b10, 2'b01, 2'b00};
      exp_rd  = '{5'd0, 5'd3, 5'd4, 5'd6};
      step();
      alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h3333_0003;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 32'h4444_0004;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd6; mdu_data_i = 32'h6666_0006;
      exp_q.push_back({5'd3, 32'h3333_0003});
      exp_q.push_back({5'd4, 32'h4444_0004});
      exp_q.push_back({5'd6, 32'h6666_0006});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++;
         if ({lsu_ready_o, mdu_ready_o} !== exp_rdy[c]) begin
            errors++;
            $display("[TB] FAIL contention_ready cycle %0d: got %b, required %b", c, {lsu_ready_o, mdu_ready_o}, exp_rdy[c]);
         end
         if (c > 0) begin
            checks++;
            if ({reg_write_en_o, rd_label_o} !== {1'b1, exp_rd[c]}) begin
               errors++;
               $display("[TB] FAIL contention_write cycle %0d: got we=%b rd=%0d, required we=1 rd=%0d",
                        c, reg_write_en_o, rd_label_o, exp_rd[c]);
            end
         end
         step();
         if (c == 0) alu_valid_i = 1'b0;
         if (c == 1) lsu_valid_i = 1'b0;
         if (c == 2) mdu_valid_i = 1'b0;
      end
   endtask

   task automatic test_x0();
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd0; mdu_data_i = 32'h1234_5678;
      @(negedge clk_i);
      checks++;
      if (mdu_ready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL x0_ready: got %b, required 1", mdu_ready_o);
      end
      step();
      mdu_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({reg_write_en_o, busy_o} !== 33'h0) begin
         errors++;
         $display("[TB] FAIL x0_no_write: got we=%b busy=%h, required we=0 busy=0", reg_write_en_o, busy_o);
      end
      step();
   endtask

   task automatic test_starvation();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd14; lsu_data_i = 32'h5A5A_0014;
      for (int c = 0; c < 8; c++) begin
         alu_valid_i = 1'b1; alu_rd_i = 5'(c + 1); alu_data_i = $urandom;
         exp_q.push_back({alu_rd_i, alu_data_i});
         @(negedge clk_i);
         checks++;
         if ({lsu_ready_o, stall_o} !== {1'b0, (c >= 5)}) begin
            errors++;
            $display("[TB] FAIL starve cycle %0d: got ready=%b stall=%b, required ready=0 stall=%b",
                     c, lsu_ready_o, stall_o, (c >= 5));
         end
         step();
      end
      alu_valid_i = 1'b0;
      exp_q.push_back({5'd14, 32'h5A5A_0014});
      @(negedge clk_i);
      checks++;
      if ({lsu_ready_o, stall_o} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL starve_grant: got ready=%b stall=%b, required ready=1 stall=1", lsu_ready_o, stall_o);
      end
      step();
      lsu_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL starve_hold: got stall=%b, required 1", stall_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL starve_release: got stall=%b, required 0", stall_o);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic lv, mv, av, el, em, mflag, stall_exp;
      int   cnt;
      lv = 1'b0; mv = 1'b0; mflag = 1'b1; stall_exp = 1'b0; cnt = 0;
      for (int c = 0; c < 60; c++) begin
         if (!lv && $urandom_range(0, 2) != 0) begin
            lv = 1'b1; lsu_rd_i = 5'($urandom_range(0, 31)); lsu_data_i = $urandom;
         end
         if (!mv && $urandom_range(0, 2) != 0) begin
            mv = 1'b1; mdu_rd_i = 5'($urandom_range(0, 31)); mdu_data_i = $urandom;
         end
         av = ($urandom_range(0, 9) < 6);
         alu_valid_i = av; alu_rd_i = 5'($urandom_range(0, 31)); alu_data_i = $urandom;
         lsu_valid_i = lv; mdu_valid_i = mv;
         el = lv && !av && (!mv || !mflag);
         em = mv && !av && (!lv || mflag);
         if (av && alu_rd_i != 5'd0) exp_q.push_back({alu_rd_i, alu_data_i});
         else if (el && lsu_rd_i != 5'd0) exp_q.push_back({lsu_rd_i, lsu_data_i});
         else if (em && mdu_rd_i != 5'd0) exp_q.push_back({mdu_rd_i, mdu_data_i});
         @(negedge clk_i);
         checks++;
         if ({lsu_ready_o, mdu_ready_o, stall_o} !== {el, em, stall_exp}) begin
            errors++;
            $display("[TB] FAIL b2b cycle %0d: got rdy=%b%b stall=%b, required rdy=%b%b stall=%b",
                     c, lsu_ready_o, mdu_ready_o, stall_o, el, em, stall_exp);
         end
         stall_exp = (cnt == 4);
         if (el || em) cnt = 0;
         else if (lv || mv) cnt = (cnt == 4) ? 4 : cnt + 1;
         else cnt = 0;
         if (el) begin mflag = 1'b1; lv = 1'b0; end
         if (em) begin mflag = 1'b0; mv = 1'b0; end
         step();
      end
      idle_inputs();
      repeat (3) step();
   endtask

   task automatic test_scoreboard();
      issue_valid_i = 1'b1; issue_rd_i = 5'd7;
      step();
      issue_valid_i = 1'b1; issue_rd_i = 5'd0;
      @(negedge clk_i);
`ifdef WB_SCOREBOARD_EN
      checks++;
      if (busy_o !== 32'h0000_0080) begin
         errors++;
         $display("[TB] FAIL sb_set: got busy=%h, required 00000080", busy_o);
      end
      step();
      issue_valid_i = 1'b1; issue_rd_i = 5'd7;
      alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h7777_0007;
      exp_q.push_back({5'd7, 32'h7777_0007});
      @(negedge clk_i);
      checks++;
      if (busy_o !== 32'h0000_0080) begin
         errors++;
         $display("[TB] FAIL sb_x0_ignored: got busy=%h, required 00000080", busy_o);
      end
      step();
      issue_valid_i = 1'b0;
      alu_data_i = 32'h7777_0017;
      exp_q.push_back({5'd7, 32'h7777_0017});
      @(negedge clk_i);
      checks++;
      if (busy_o !== 32'h0000_0080) begin
         errors++;
         $display("[TB] FAIL sb_set_wins: got busy=%h, required 00000080", busy_o);
      end
      step();
      alu_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (busy_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sb_clear: got busy=%h, required 00000000", busy_o);
      end
`else
      checks++;
      if (busy_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sb_disabled: got busy=%h, required 00000000", busy_o);
      end
`endif
      idle_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_contention();
      test_x0();
      test_starvation();
      test_back_to_back();
      test_scoreboard();
      repeat (2) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL final_pending: got %0d writes outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
